// File: rtl/axi_lite_cmd_arbiter_if.sv
// Purpose: command/response lanes of NUM_REQ requesters plus start/done link to one AXI-Lite master.
// Latency: none (wires only).
// Backpressure: requesters see req_ready as a one-cycle accept pulse; the master side is start/done pulses.
interface axi_lite_cmd_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int GW = $clog2(NUM_REQ);

  // requester command side
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ*4-1:0]  req_wstrb;

  // requester response side
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_resp;

  // toward the AXI-Lite master
  logic                  start_read;
  logic                  start_write;
  logic [31:0]           addr;
  logic [31:0]           data;
  logic [3:0]            wstrb;
  logic                  m_rdone;
  logic                  m_wdone;
  logic [31:0]           m_rdata;
  logic [1:0]            m_resp;

  // status
  logic                  busy;
  logic [GW-1:0]         grant;

  // arbiter view
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  m_rdone, m_wdone, m_rdata, m_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
    output start_read, start_write, addr, data, wstrb,
    output busy, grant
  );

  // requester/master-model view
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output m_rdone, m_wdone, m_rdata, m_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  start_read, start_write, addr, data, wstrb,
    input  busy, grant
  );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// Purpose: round-robin share of one AXI-Lite master among NUM_REQ command requesters, one command in flight.
// Latency: accept -> start pulse 1 cycle; master done -> rsp_valid 1 cycle; back-to-back 4 cycles + slave latency.
// Backpressure: req_ready only pulses in IDLE; a stalled slave is cut off after TIMEOUT WAIT cycles (0 = never).
module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  axi_lite_cmd_arbiter_if.slave bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
  localparam logic [1:0]    RESP_TIMEOUT = 2'b11;

  // state
  logic [1:0]         r_state;
  logic [GW-1:0]      r_last_grant;
  logic [GW-1:0]      r_grant;

  // latched command of the granted requester
  logic               r_write;
  logic [31:0]        r_addr;
  logic [31:0]        r_data;
  logic [3:0]         r_wstrb;

  // WAIT-state cycle counter
  logic [CW-1:0]      r_cnt;

  // response registers, held between responses
  logic [31:0]        r_rsp_rdata;
  logic [1:0]         r_rsp_resp;

  // arbitration and selection
  logic               w_found;
  logic [GW-1:0]      w_winner;
  logic               w_sel_write;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_sel_wstrb;

  // handshake helpers
  logic               w_idle;
  logic               w_accept;
  logic               w_done;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [NUM_REQ-1:0] w_rsp_valid;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && w_found;

  // Round-robin pick: lowest requester above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (i <= int'(r_last_grant))) begin
        w_found  = 1'b1;
        w_winner = GW'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (i > int'(r_last_grant))) begin
        w_found  = 1'b1;
        w_winner = GW'(i);
      end
    end
  end

  // Mux the winner's command fields out of the packed requester buses.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GW'(i)) begin
        w_sel_write = bus.req_write[i];
        w_sel_addr  = bus.req_addr[32*i +: 32];
        w_sel_wdata = bus.req_wdata[32*i +: 32];
        w_sel_wstrb = bus.req_wstrb[4*i +: 4];
      end
    end
  end

  // Completion must match the latched direction; the other done pulse is ignored.
  assign w_done    = r_write ? bus.m_wdone : bus.m_rdone;
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == CW'(TIMEOUT));

  // Main FSM: IDLE -> ISSUE (1 cycle) -> WAIT -> RESP (1 cycle) -> IDLE.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_found) r_state <= S_ISSUE;
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT:  if (w_done || w_timeout) r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Grant bookkeeping: pointer starts at NUM_REQ-1 so requester 0 wins first after reset.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_last_grant <= LAST_INIT;
      r_grant      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_winner;
      r_grant      <= w_winner;
    end
  end

  // Capture the accepted command once; later requester changes do not reach the master.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wstrb <= '0;
    end else if (w_accept) begin
      r_write <= w_sel_write;
      r_addr  <= w_sel_addr;
      r_data  <= w_sel_wdata;
      r_wstrb <= w_sel_wstrb;
    end
  end

  // Count WAIT cycles from zero; only meaningful when a timeout limit is configured.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && !w_done && (TIMEOUT != 0)) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Register the response on leaving WAIT; a completion in the last allowed cycle beats the timeout.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else if (r_state == S_WAIT) begin
      if (w_done) begin
        r_rsp_rdata <= r_write ? 32'h0 : bus.m_rdata;
        r_rsp_resp  <= bus.m_resp;
      end else if (w_timeout) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_resp  <= RESP_TIMEOUT;
      end
    end
  end

  // One-hot accept and response pulses; accept is masked while reset is asserted.
  always_comb begin
    w_req_ready = '0;
    w_rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_ready[i] = areset_n && w_accept && (w_winner == GW'(i));
      w_rsp_valid[i] = (r_state == S_RESP) && (r_grant == GW'(i));
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_resp    = r_rsp_resp;
  assign bus.start_write = (r_state == S_ISSUE) && r_write;
  assign bus.start_read  = (r_state == S_ISSUE) && !r_write;
  assign bus.addr        = r_addr;
  assign bus.data        = r_data;
  assign bus.wstrb       = r_wstrb;
  assign bus.busy        = !w_idle;
  assign bus.grant       = r_grant;

  // Structural invariants of the start/accept/response pulses.
  a_start_excl : assert property (@(posedge aclk) disable iff (!areset_n)
    !(bus.start_read && bus.start_write));
  a_ready_onehot : assert property (@(posedge aclk) disable iff (!areset_n)
    $onehot0(bus.req_ready));
  a_rsp_onehot : assert property (@(posedge aclk) disable iff (!areset_n)
    $onehot0(bus.rsp_valid));
  a_ready_idle_only : assert property (@(posedge aclk) disable iff (!areset_n)
    (r_state != S_IDLE) |-> (bus.req_ready == '0));

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter with three requesters and an 8-cycle timeout.
module tb_axi_lite_cmd_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic aclk     = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  axi_lite_cmd_arbiter_if #(.NUM_REQ(N)) bus ();

  axi_lite_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  bit          m_idle;
  int          m_last, m_grant, m_cyc, m_issue, m_resp;
  bit          m_wr;
  logic [31:0] m_addr, m_data, m_rdata_q;
  logic [3:0]  m_strb;
  logic [1:0]  m_resp_q;

  task automatic model_reset();
    m_idle = 1; m_last = N - 1; m_grant = 0; m_cyc = 0; m_issue = -1; m_resp = -1;
    m_wr = 0; m_addr = 0; m_data = 0; m_strb = 0; m_rdata_q = 0; m_resp_q = 0;
  endtask

  initial model_reset();

  always @(negedge aclk) begin
    int win;
    logic [N-1:0] one, e_ready, e_rv;
    one = 1;
    if (!areset_n) begin
      check("rst_busy", bus.busy, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_start", {bus.start_read, bus.start_write}, 0);
      check("rst_addr", bus.addr, 0);
      check("rst_data", bus.data, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_grant", bus.grant, 0);
      model_reset();
    end else begin
      win = -1;
      if (m_idle) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (win < 0 && bus.req_valid[i]) win = i;
        end
      end
      e_ready = (win >= 0) ? (one << win) : '0;
      e_rv    = (!m_idle && m_cyc == m_resp) ? (one << m_grant) : '0;
      check("req_ready", bus.req_ready, e_ready);
      check("rsp_valid", bus.rsp_valid, e_rv);
      check("busy", bus.busy, !m_idle);
      check("start_write", bus.start_write, !m_idle && m_cyc == m_issue && m_wr);
      check("start_read", bus.start_read, !m_idle && m_cyc == m_issue && !m_wr);
      check("grant", bus.grant, m_grant);
      check("rsp_rdata", bus.rsp_rdata, m_rdata_q);
      check("rsp_resp", bus.rsp_resp, m_resp_q);
      if (!m_idle) begin
        check("addr", bus.addr, m_addr);
        check("data", bus.data, m_data);
        check("wstrb", bus.wstrb, m_strb);
      end
      // advance the model with this cycle's inputs
      if (m_idle) begin
        if (win >= 0) begin
          m_idle = 0; m_grant = win; m_last = win;
          m_wr   = bus.req_write[win];
          m_addr = bus.req_addr[win*32 +: 32];
          m_data = bus.req_wdata[win*32 +: 32];
          m_strb = bus.req_wstrb[win*4 +: 4];
          m_issue = m_cyc + 1; m_resp = -1;
        end
      end else if (m_cyc == m_resp) begin
        m_idle = 1;
      end else if (m_cyc > m_issue && m_resp < 0) begin
        if (m_wr ? bus.m_wdone : bus.m_rdone) begin
          m_resp = m_cyc + 1;
          m_rdata_q = m_wr ? 32'h0 : bus.m_rdata;
          m_resp_q  = bus.m_resp;
        end else if (TO != 0 && (m_cyc - m_issue) == TO) begin
          m_resp = m_cyc + 1; m_rdata_q = 0; m_resp_q = 2'b11;
        end
      end
      m_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wstrb = '0; bus.m_rdone = 0; bus.m_wdone = 0; bus.m_rdata = 0; bus.m_resp = 0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 30 && !ok; c++) begin
      tick();
      @(negedge aclk);
      if (!bus.busy) ok = 1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gseq [4];
    int got, bad_ready, n;
    bit found;
    int pdone;

    clear_inputs();
    bus.req_valid = '1;                         // must stay unacknowledged during reset
    tick(); tick();
    @(negedge aclk);
    check("t0_reset_ready", bus.req_ready, 0);
    check("t0_reset_busy", bus.busy, 0);

    // write from requester 0
    tick();
    areset_n = 1;
    bus.req_valid = 3'b001; bus.req_write = 3'b001;
    bus.req_addr[31:0] = 32'h10; bus.req_wdata[31:0] = 32'hDEADBEEF; bus.req_wstrb[3:0] = 4'hF;
    @(negedge aclk);
    check("t1_ready", bus.req_ready, 3'b001);
    tick(); bus.req_valid = '0; bus.req_addr[31:0] = 32'h99;
    @(negedge aclk);
    check("t1_start_write", bus.start_write, 1);
    check("t1_start_read", bus.start_read, 0);
    check("t1_addr", bus.addr, 32'h10);
    check("t1_data", bus.data, 32'hDEADBEEF);
    check("t1_wstrb", bus.wstrb, 4'hF);
    tick(); tick(); tick();
    bus.m_wdone = 1; bus.m_resp = 2'b00;
    @(negedge aclk);
    check("t1_no_rsp_yet", bus.rsp_valid, 0);
    tick(); bus.m_wdone = 0;
    @(negedge aclk);
    check("t1_rsp_valid", bus.rsp_valid, 3'b001);
    check("t1_rsp_resp", bus.rsp_resp, 2'b00);
    tick();
    @(negedge aclk);
    check("t1_idle", bus.busy, 0);

    // read back from requester 1
    tick();
    bus.req_valid = 3'b010; bus.req_write = 3'b000; bus.req_addr[63:32] = 32'h10;
    bus.m_rdata = 32'h0BADF00D;
    @(negedge aclk);
    check("t2_ready", bus.req_ready, 3'b010);
    tick(); bus.req_valid = '0;
    @(negedge aclk);
    check("t2_start_read", bus.start_read, 1);
    check("t2_addr_issue", bus.addr, 32'h10);
    tick();
    @(negedge aclk);
    check("t2_addr_wait", bus.addr, 32'h10);
    tick(); bus.m_rdone = 1; bus.m_rdata = 32'hDEADBEEF; bus.m_resp = 2'b00;
    @(negedge aclk);
    check("t2_addr_done", bus.addr, 32'h10);
    tick(); bus.m_rdone = 0; bus.m_rdata = 32'h0BADF00D;
    @(negedge aclk);
    check("t2_rsp_valid", bus.rsp_valid, 3'b010);
    check("t2_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    check("t2_rsp_resp", bus.rsp_resp, 2'b00);

    // arbitration from reset: requesters 0 and 1 always valid
    tick(); areset_n = 0;
    tick(); tick();
    areset_n = 1;
    bus.req_valid = 3'b011; bus.m_rdone = 1; bus.m_wdone = 1; bus.m_resp = 0;
    got = 0; bad_ready = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge aclk);
      if (bus.req_ready != 0 && bus.busy) bad_ready++;
      if (bus.req_ready != 0) begin gseq[got] = bus.req_ready; got++; end
      tick();
    end
    check("t3_grant_count", got, 4);
    check("t3_grant0", gseq[0], 3'b001);
    check("t3_grant1", gseq[1], 3'b010);
    check("t3_grant2", gseq[2], 3'b001);
    check("t3_grant3", gseq[3], 3'b010);
    check("t3_ready_busy", bad_ready, 0);
    bus.req_valid = '0; bus.m_rdone = 0;
    wait_idle("t3_drain");

    // timeout: read from requester 2, only wrong-type done pulses arrive
    tick();
    bus.m_wdone = 0;
    bus.req_valid = 3'b100; bus.req_write = 3'b000; bus.req_addr[95:64] = 32'h40;
    @(negedge aclk);
    check("t4_ready", bus.req_ready, 3'b100);
    tick(); bus.req_valid = '0; bus.m_wdone = 1;
    @(negedge aclk);
    check("t4_start_read", bus.start_read, 1);
    n = 0; found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick(); n++;
      @(negedge aclk);
      if (bus.rsp_valid != 0) found = 1;
    end
    check("t4_rsp_seen", found, 1);
    check("t4_latency", n, 9);
    check("t4_rsp_valid", bus.rsp_valid, 3'b100);
    check("t4_rsp_resp", bus.rsp_resp, 2'b11);
    check("t4_rsp_rdata", bus.rsp_rdata, 0);
    tick(); bus.m_wdone = 0;
    bus.req_valid = 3'b001; bus.req_write = 3'b001;
    @(negedge aclk);
    check("t4_next_ready", bus.req_ready, 3'b001);
    tick(); bus.req_valid = '0; bus.m_wdone = 1; bus.m_resp = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      @(negedge aclk);
      if (bus.rsp_valid != 0) found = 1;
    end
    check("t4_next_rsp", {found, bus.rsp_valid, bus.rsp_resp}, {1'b1, 3'b001, 2'b00});
    tick(); bus.m_wdone = 0;

    // wrong-type done during a write, then done pulses while idle
    tick();
    bus.req_valid = 3'b010; bus.req_write = 3'b010; bus.req_addr[63:32] = 32'h20;
    @(negedge aclk);
    check("t5_ready", bus.req_ready, 3'b010);
    tick(); bus.req_valid = '0;
    tick(); bus.m_rdone = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("t5_no_rsp", bus.rsp_valid, 0);
      tick();
    end
    bus.m_rdone = 0; bus.m_wdone = 1; bus.m_resp = 2'b10;
    @(negedge aclk);
    check("t5_no_rsp_done_cycle", bus.rsp_valid, 0);
    tick(); bus.m_wdone = 0;
    @(negedge aclk);
    check("t5_rsp_valid", bus.rsp_valid, 3'b010);
    check("t5_rsp_resp", bus.rsp_resp, 2'b10);
    tick(); bus.m_rdone = 1; bus.m_wdone = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("t5_idle_done", {bus.rsp_valid, bus.busy}, 0);
      tick();
    end
    bus.m_rdone = 0; bus.m_wdone = 0;

    // reset during WAIT
    bus.req_valid = 3'b001; bus.req_write = 3'b000;
    bus.req_addr[31:0] = 32'h80; bus.req_wdata[31:0] = 32'h55;
    @(negedge aclk);
    check("t6_ready", bus.req_ready, 3'b001);
    tick(); bus.req_valid = '0;
    tick(); tick();
    @(posedge aclk);
    #3;
    areset_n = 0; bus.req_valid = 3'b011;
    #1;
    check("t6_async_busy", bus.busy, 0);
    check("t6_async_start", {bus.start_read, bus.start_write}, 0);
    check("t6_async_rsp", bus.rsp_valid, 0);
    check("t6_async_ready", bus.req_ready, 0);
    check("t6_async_addr", bus.addr, 0);
    check("t6_async_data", bus.data, 0);
    tick(); tick();
    areset_n = 1;
    @(negedge aclk);
    check("t6_first_ready", bus.req_ready, 3'b001);
    tick(); bus.req_valid = '0; bus.m_rdone = 1; bus.m_wdone = 1;
    wait_idle("t6_drain");
    tick();
    clear_inputs();

    // randomized traffic
    pdone = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(3))
          0:       pdone = 0;
          1:       pdone = 5;
          2:       pdone = 30;
          default: pdone = 90;
        endcase
      end
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = ($urandom_range(99) < 60);
        bus.req_write[i] = $urandom_range(1);
        bus.req_addr[32*i +: 32]  = $urandom;
        bus.req_wdata[32*i +: 32] = $urandom;
        bus.req_wstrb[4*i +: 4]   = 4'($urandom);
      end
      bus.m_rdone = ($urandom_range(99) < pdone);
      bus.m_wdone = ($urandom_range(99) < pdone);
      bus.m_rdata = $urandom;
      bus.m_resp  = 2'($urandom);
      tick();
    end
    clear_inputs();
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
